// File: rtl/conway_pkg.sv
// Shared types for the BRAM stream reader.
// Holds the scan FSM state encoding.
package conway_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/bram_stream_reader_if.sv
// Stream output bundle of the BRAM stream reader.
// Master drives payload/valid/last, slave drives ready.
interface bram_stream_reader_if #(
  parameter int DATA_WIDTH = 8
);

  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_valid;
  logic                  m_ready;
  logic                  m_last;

  modport master (
    output m_data,
    output m_valid,
    output m_last,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_valid,
    input  m_last,
    output m_ready
  );

endinterface

// File: rtl/bram_reader_fifo.sv
// Two-entry skid buffer for BRAM return data.
// Each entry carries the data word and its last tag.
module bram_reader_fifo #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          i_flush,
  input  logic          i_push,
  input  logic          i_pop,
  input  logic [DW-1:0] i_data,
  input  logic          i_last,
  output logic [DW-1:0] o_data,
  output logic          o_last,
  output logic [1:0]    o_count
);

  logic [DW:0] r_mem [2];
  logic        r_wr;
  logic        r_rd;
  logic [1:0]  r_cnt;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < 2; i++) r_mem[i] <= '0;
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else if (i_flush) begin
      r_wr  <= 1'b0;
      r_rd  <= 1'b0;
      r_cnt <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr] <= {i_last, i_data};
        r_wr        <= ~r_wr;
      end
      if (i_pop) r_rd <= ~r_rd;
      r_cnt <= r_cnt + 2'(i_push) - 2'(i_pop);
    end
  end

  assign o_data  = r_mem[r_rd][DW-1:0];
  assign o_last  = r_mem[r_rd][DW];
  assign o_count = r_cnt;

endmodule

// File: rtl/bram_stream_reader.sv
// Scans BRAM addresses 0..DEPTH-1 once per start and
// streams the words out with valid/ready backpressure.
module bram_stream_reader
  import conway_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 200,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  start,
  input  logic                  abort,
  output logic [ADDR_WIDTH-1:0] read_addr,
  output logic                  read_enable,
  input  logic [DATA_WIDTH-1:0] read_data,
  output logic                  busy,
  output logic                  done,
  bram_stream_reader_if.master  m
);

  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR =
    ADDR_WIDTH'(DEPTH - 1);

  state_t                  r_state;
  state_t                  w_next;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic                    r_inflight;
  logic                    r_infl_last;
  logic                    r_done;
  logic                    w_re;
  logic                    w_pop;
  logic                    w_push;
  logic                    w_flush;
  logic                    w_last_addr;
  logic [1:0]              w_occ;
  logic [2:0]              w_load;
  logic [DATA_WIDTH-1:0]   w_head;
  logic                    w_head_last;

  assign w_pop       = m.m_valid & m.m_ready;
  assign w_load      = 3'(w_occ) + 3'(r_inflight);
  assign w_last_addr = (r_addr == LAST_ADDR);
  assign w_flush     = abort & (r_state != ST_IDLE);
  assign w_push      = r_inflight & ~w_flush;

  // Only issue a read when its return is sure to find a free slot.
  always_comb begin
    w_next = r_state;
    w_re   = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (start) w_next = ST_RUN;
      end
      ST_RUN: begin
        w_re = (w_load <= 3'd1 + 3'(w_pop));
        if (w_re && w_last_addr) w_next = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (w_pop && w_head_last) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
    if (abort) w_next = ST_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_state <= ST_IDLE;
    else         r_state <= w_next;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_addr      <= '0;
      r_inflight  <= 1'b0;
      r_infl_last <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      if (r_state == ST_IDLE && start && !abort)
        r_addr <= '0;
      else if (w_re && !w_last_addr)
        r_addr <= r_addr + 1'b1;
      r_inflight  <= w_re & ~abort;
      r_infl_last <= w_last_addr;
      r_done      <= (r_state == ST_DRAIN) & w_pop
                   & w_head_last & ~abort;
    end
  end

  bram_reader_fifo #(
    .DW (DATA_WIDTH)
  ) u_fifo (
    .clk     (clk),
    .resetn  (resetn),
    .i_flush (w_flush),
    .i_push  (w_push),
    .i_pop   (w_pop & ~w_flush),
    .i_data  (read_data),
    .i_last  (r_infl_last),
    .o_data  (w_head),
    .o_last  (w_head_last),
    .o_count (w_occ)
  );

  assign read_addr   = r_addr;
  assign read_enable = w_re;
  assign busy        = (r_state != ST_IDLE);
  assign done        = r_done;
  assign m.m_valid   = (w_occ != 2'd0);
  assign m.m_data    = w_head;
  assign m.m_last    = w_head_last;

endmodule
